// File: rtl/ovr_i_monitor.sv
// rtl/ovr_i_monitor.sv - per-PWM-period over-current qualification with latched shutdown
module ovr_i_monitor #(
    parameter int TRIP_PERIODS = 4,
    parameter int EVT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             OVR_I_in,
    input  logic             PWM_synch,
    input  logic             ovr_I_blank,
    input  logic             clr_fault,
    output logic             ovr_I_shtdwn,
    output logic             period_bad,
    output logic [3:0]       bad_cnt,
    output logic [EVT_W-1:0] evt_cnt
);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_MONITOR = 2'd1,
        S_TRIPPED = 2'd2
    } state_t;

    localparam logic [3:0] TRIP_CNT = 4'(TRIP_PERIODS);

    state_t state, state_next;

    logic ovr_meta, ovr_s;
    logic blank_q1, blank_d;
    logic synch_q1, synch_d;
    logic hit, hit_next;
    logic qual;
    logic [3:0] bad_inc;
    logic [3:0] cnt_next;
    logic [EVT_W-1:0] evt_next;
    logic pb_next, sd_next;

    // Blank and synch go through the same two stages as the comparator
    // so that all three stay cycle-aligned at the qualification point.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_meta <= 1'b0;
            ovr_s    <= 1'b0;
            blank_q1 <= 1'b0;
            blank_d  <= 1'b0;
            synch_q1 <= 1'b0;
            synch_d  <= 1'b0;
        end else begin
            ovr_meta <= OVR_I_in;
            ovr_s    <= ovr_meta;
            blank_q1 <= ovr_I_blank;
            blank_d  <= blank_q1;
            synch_q1 <= PWM_synch;
            synch_d  <= synch_q1;
        end
    end

    assign qual    = ovr_s & ~blank_d;
    assign bad_inc = (bad_cnt == 4'hF) ? bad_cnt : bad_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_WAIT;
            hit          <= 1'b0;
            period_bad   <= 1'b0;
            bad_cnt      <= 4'd0;
            evt_cnt      <= '0;
            ovr_I_shtdwn <= 1'b0;
        end else begin
            state        <= state_next;
            hit          <= hit_next;
            period_bad   <= pb_next;
            bad_cnt      <= cnt_next;
            evt_cnt      <= evt_next;
            ovr_I_shtdwn <= sd_next;
        end
    end

    always_comb begin
        state_next = state;
        hit_next   = hit;
        pb_next    = 1'b0;
        cnt_next   = bad_cnt;
        evt_next   = evt_cnt;
        sd_next    = ovr_I_shtdwn;
        case (state)
            S_WAIT: begin
                // Partial period after reset or clear is never judged.
                hit_next = 1'b0;
                if (synch_d) begin
                    state_next = S_MONITOR;
                end
            end
            S_MONITOR: begin
                if (synch_d) begin
                    hit_next = 1'b0;
                    if (hit || qual) begin
                        pb_next  = 1'b1;
                        cnt_next = bad_inc;
                        evt_next = (evt_cnt == {EVT_W{1'b1}}) ? evt_cnt : evt_cnt + EVT_W'(1);
                        if (bad_inc == TRIP_CNT) begin
                            sd_next    = 1'b1;
                            state_next = S_TRIPPED;
                        end
                    end else begin
                        cnt_next = 4'd0;
                    end
                end else if (qual) begin
                    hit_next = 1'b1;
                end
            end
            S_TRIPPED: begin
                hit_next = 1'b0;
                sd_next  = 1'b1;
                if (clr_fault) begin
                    sd_next    = 1'b0;
                    cnt_next   = 4'd0;
                    state_next = S_WAIT;
                end
            end
            default: begin
                hit_next   = 1'b0;
                state_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_ovr_i_monitor.sv
// tb/tb_ovr_i_monitor.sv - directed self-checking bench for ovr_i_monitor
module tb_ovr_i_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       OVR_I_in;
    logic       PWM_synch;
    logic       ovr_I_blank;
    logic       clr_fault;
    logic       ovr_I_shtdwn;
    logic       period_bad;
    logic [3:0] bad_cnt;
    logic [7:0] evt_cnt;

    int checks   = 0;
    int failures = 0;
    int pb_total = 0;
    int sd_total = 0;
    int pb_mark;
    int sd_mark;

    ovr_i_monitor #(.TRIP_PERIODS(4), .EVT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .OVR_I_in     (OVR_I_in),
        .PWM_synch    (PWM_synch),
        .ovr_I_blank  (ovr_I_blank),
        .clr_fault    (clr_fault),
        .ovr_I_shtdwn (ovr_I_shtdwn),
        .period_bad   (period_bad),
        .bad_cnt      (bad_cnt),
        .evt_cnt      (evt_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_bad)   pb_total = pb_total + 1;
        if (ovr_I_shtdwn) sd_total = sd_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One PWM period: synch at c=0, blanking for c<16, comparator high for
    // [os, os+ol). Values sampled at c=3 reflect the judgement of the
    // previous period; c=2 is the cycle just before that update lands.
    task automatic per(input string tag, input int len, input int os, input int ol,
                       input int clr_at, input int exp_cnt, input int exp_pb,
                       input int exp_sd2, input int exp_sd3);
        logic [3:0] cnt3;
        logic       pb3, sd2, sd3;
        cnt3 = 4'd0; pb3 = 1'b0; sd2 = 1'b0; sd3 = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (c == 2) sd2 = ovr_I_shtdwn;
            if (c == 3) begin
                cnt3 = bad_cnt;
                pb3  = period_bad;
                sd3  = ovr_I_shtdwn;
            end
            PWM_synch   = (c == 0);
            ovr_I_blank = (c < 16);
            OVR_I_in    = (c >= os) && (c < os + ol);
            clr_fault   = (c == clr_at);
            tick();
        end
        clr_fault = 1'b0;
        chk({tag, "_bad_cnt"}, int'(cnt3), exp_cnt);
        chk({tag, "_period_bad"}, int'(pb3), exp_pb);
        chk({tag, "_shtdwn_pre"}, int'(sd2), exp_sd2);
        chk({tag, "_shtdwn_post"}, int'(sd3), exp_sd3);
    endtask

    task automatic idle(input int n, input logic ovr);
        for (int i = 0; i < n; i++) begin
            PWM_synch   = 1'b0;
            ovr_I_blank = 1'b0;
            OVR_I_in    = ovr;
            tick();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_shtdwn"}, int'(ovr_I_shtdwn), 0);
        chk({tag, "_period_bad"}, int'(period_bad), 0);
        chk({tag, "_bad_cnt"}, int'(bad_cnt), 0);
        chk({tag, "_evt_cnt"}, int'(evt_cnt), 0);
    endtask

    initial begin
        rst = 1'b1; OVR_I_in = 1'b0; PWM_synch = 1'b0; ovr_I_blank = 1'b0; clr_fault = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        // Clean periods, full-length PWM period
        pb_mark = pb_total; sd_mark = sd_total;
        for (int i = 0; i < 5; i++) per("clean", 2048, 0, 0, -1, 0, 0, 0, 0);
        chk("clean_pb_count", pb_total - pb_mark, 0);
        chk("clean_sd_cycles", sd_total - sd_mark, 0);
        chk("clean_evt", int'(evt_cnt), 0);

        // Comparator active only inside blanking
        for (int i = 0; i < 6; i++) per("blank", 256, 2, 12, -1, 0, 0, 0, 0);
        chk("blank_pb_count", pb_total - pb_mark, 0);
        chk("blank_evt", int'(evt_cnt), 0);

        // bad, bad, bad, good, bad
        per("pat1", 256, 100, 20, -1, 0, 0, 0, 0);
        per("pat2", 256, 100, 20, -1, 1, 1, 0, 0);
        per("pat3", 256, 100, 20, -1, 2, 1, 0, 0);
        per("pat4", 256, 0, 0, -1, 3, 1, 0, 0);
        per("pat5", 256, 100, 20, -1, 0, 0, 0, 0);
        per("pat6", 256, 0, 0, -1, 1, 1, 0, 0);
        chk("pat_evt", int'(evt_cnt), 4);
        chk("pat_sd_cycles", sd_total - sd_mark, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst2");
        idle(40, 1'b0);

        // Trip after four bad periods, then hold comparator high while tripped
        pb_mark = pb_total;
        per("trip1", 256, 100, 20, -1, 0, 0, 0, 0);
        per("trip2", 256, 100, 20, -1, 1, 1, 0, 0);
        per("trip3", 256, 100, 20, -1, 2, 1, 0, 0);
        per("trip4", 256, 100, 20, -1, 3, 1, 0, 0);
        per("trip5", 256, 0, 256, -1, 4, 1, 0, 1);
        chk("trip_pb_count", pb_total - pb_mark, 4);
        chk("trip_evt", int'(evt_cnt), 4);
        per("hold1", 256, 0, 256, -1, 4, 0, 1, 1);
        per("hold2", 256, 0, 256, -1, 4, 0, 1, 1);
        chk("hold_evt", int'(evt_cnt), 4);
        chk("hold_shtdwn", int'(ovr_I_shtdwn), 1);
        OVR_I_in = 1'b1; clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("clr_shtdwn", int'(ovr_I_shtdwn), 0);
        chk("clr_bad_cnt", int'(bad_cnt), 0);
        chk("clr_evt", int'(evt_cnt), 4);
        idle(30, 1'b1);
        per("realign", 256, 100, 20, -1, 0, 0, 0, 0);
        per("resume", 256, 0, 0, -1, 1, 1, 0, 0);
        chk("resume_evt", int'(evt_cnt), 5);

        // Clear coinciding with a boundary while tripped
        per("t2a", 256, 100, 20, -1, 0, 0, 0, 0);
        per("t2b", 256, 100, 20, -1, 1, 1, 0, 0);
        per("t2c", 256, 100, 20, -1, 2, 1, 0, 0);
        per("t2d", 256, 100, 20, -1, 3, 1, 0, 0);
        per("t2e", 256, 0, 0, -1, 4, 1, 0, 1);
        chk("t2_evt", int'(evt_cnt), 9);
        per("clr_bnd", 256, 100, 20, 2, 0, 0, 1, 0);
        per("clr_wait", 256, 100, 20, -1, 0, 0, 0, 0);
        per("clr_judge", 256, 100, 20, -1, 1, 1, 0, 0);
        chk("clr_judge_evt", int'(evt_cnt), 10);

        // Reset mid-period while tripped
        per("t3b", 256, 100, 20, -1, 2, 1, 0, 0);
        per("t3c", 256, 100, 20, -1, 3, 1, 0, 0);
        per("t3d", 256, 0, 0, -1, 4, 1, 0, 1);
        chk("t3_evt", int'(evt_cnt), 13);
        idle(20, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst3");
        idle(20, 1'b1);
        idle(20, 1'b0);
        per("post_rst1", 256, 0, 0, -1, 0, 0, 0, 0);
        per("post_rst2", 256, 0, 0, -1, 0, 0, 0, 0);
        chk("post_rst_evt", int'(evt_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
